// File: rtl/flits_sender_pkg.sv
// Flit format macros, FSM encoding and flit-type helper shared by the flits_sender slice.
// The macros are used from NIC-defines.v when it is included first; otherwise defaults apply.
`ifndef FLIT_WIDTH
`define FLIT_WIDTH 32
`define MAX_PACKET_LENGHT 8
`define N_BITS_FLIT_TYPE 2
`define FLIT_TYPE_BITS `FLIT_WIDTH-1:`FLIT_WIDTH-`N_BITS_FLIT_TYPE
`define HEAD_FLIT 2'b00
`define BODY_FLIT 2'b01
`define TAIL_FLIT 2'b10
`define HEAD_TAIL_FLIT 2'b11
`endif

package flits_sender_pkg;

  localparam int FLIT_W    = `FLIT_WIDTH;
  localparam int MAX_FLITS = `MAX_PACKET_LENGHT;
  localparam int LINK_W    = FLIT_W * MAX_FLITS;
  localparam int TYPE_W    = `N_BITS_FLIT_TYPE;

  typedef logic [FLIT_W-1:0] flit_t;

  typedef enum logic [2:0] {
    IDLE      = 3'b001,
    SENDING   = 3'b010,
    WAIT_FREE = 3'b100
  } state_t;

  // A tail or head_tail flit closes the packet.
  function automatic logic is_tail(input flit_t f);
    logic [TYPE_W-1:0] t;
    t = f[`FLIT_TYPE_BITS];
    return (t == `TAIL_FLIT) || (t == `HEAD_TAIL_FLIT);
  endfunction

endpackage

// File: rtl/flits_sender_if.sv
// Handshake with the packetizer stage plus the flit/credit link to the NoC router.
interface flits_sender_if;
  import flits_sender_pkg::*;

  logic              r_msg_to_pkt_i;
  logic [LINK_W-1:0] in_link_i;
  logic              g_msg_to_pkt_o;
  flit_t             out_link_o;
  logic              is_valid_o;
  logic              credit_signal_i;
  logic              free_signal_i;

  modport master (
    input  r_msg_to_pkt_i, in_link_i, credit_signal_i, free_signal_i,
    output g_msg_to_pkt_o, out_link_o, is_valid_o
  );

  modport slave (
    output r_msg_to_pkt_i, in_link_i, credit_signal_i, free_signal_i,
    input  g_msg_to_pkt_o, out_link_o, is_valid_o
  );
endinterface

// File: rtl/flits_sender_credit_counter.sv
// Saturating count of free flit slots in the downstream router input buffer.
module credit_counter #(
  parameter int N_CREDITS     = 4,
  parameter int N_BITS_CREDIT = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     inc,
  input  logic                     dec,
  output logic [N_BITS_CREDIT-1:0] count
);

  localparam logic [N_BITS_CREDIT-1:0] FULL = N_BITS_CREDIT'(N_CREDITS);

  // NOTE: sequential state is updated with non-blocking assignments only, so every
  // flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= FULL;
    end else if (inc && !dec && (count != FULL)) begin
      count <= count + N_BITS_CREDIT'(1);
    end else if (dec && !inc && (count != '0)) begin
      count <= count - N_BITS_CREDIT'(1);
    end
  end

endmodule

// File: rtl/flits_sender.sv
// Serialises a granted packet into flits on the NoC link under credit flow control.
// Define NIC_TX_ATOMIC_ALLOC_EN to hold each packet until the downstream buffer reports idle.
module flits_sender
  import flits_sender_pkg::*;
#(
  parameter int N_BITS_POINTER = 3,
  parameter int N_CREDITS      = 4,
  parameter int N_BITS_CREDIT  = 3
) (
  input logic            clk,
  input logic            rst,
  flits_sender_if.master bus
);

  state_t                    state_q, state_d;
  logic [N_BITS_POINTER-1:0] ptr_q;
  flit_t                     flits_q [MAX_FLITS];
  logic [N_BITS_CREDIT-1:0]  credits;
  logic                      grant;
  logic                      send;
  logic                      head_ok;
  logic                      last_flit;
  flit_t                     cur_flit;

  assign cur_flit  = flits_q[ptr_q];
  assign last_flit = is_tail(cur_flit) || (ptr_q == N_BITS_POINTER'(MAX_FLITS - 1));

`ifdef NIC_TX_ATOMIC_ALLOC_EN
  logic idle_q;

  // A head may only leave once the router buffer has drained the previous packet.
  assign head_ok = (ptr_q != '0) || idle_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      idle_q <= 1'b1;
    end else if (send && (ptr_q == '0)) begin
      idle_q <= 1'b0;
    end else if (bus.free_signal_i) begin
      idle_q <= 1'b1;
    end
  end
`else
  logic unused_free;

  assign head_ok     = 1'b1;
  assign unused_free = bus.free_signal_i;
`endif

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    send    = 1'b0;
    case (state_q)
      IDLE: begin
        grant = bus.r_msg_to_pkt_i;
        if (grant) state_d = SENDING;
      end
      SENDING: begin
        send = (credits != '0) && head_ok;
        if (send && last_flit) begin
`ifdef NIC_TX_ATOMIC_ALLOC_EN
          state_d = WAIT_FREE;
`else
          state_d = IDLE;
`endif
        end
      end
`ifdef NIC_TX_ATOMIC_ALLOC_EN
      WAIT_FREE: begin
        if (idle_q || bus.free_signal_i) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
    // Outputs stay quiet while reset is held, even before the state flops clear.
    if (rst) begin
      grant = 1'b0;
      send  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        ptr_q <= '0;
      end else if (send) begin
        ptr_q <= ptr_q + N_BITS_POINTER'(1);
      end
    end
  end

  // NOTE: packet storage is deliberately not reset; it is always rewritten on grant
  // before any flit of it can be sent.
  always_ff @(posedge clk) begin
    if (grant) begin
      for (int i = 0; i < MAX_FLITS; i++) begin
        flits_q[i] <= bus.in_link_i[i*FLIT_W +: FLIT_W];
      end
    end
  end

  credit_counter #(
    .N_CREDITS     (N_CREDITS),
    .N_BITS_CREDIT (N_BITS_CREDIT)
  ) u_credit (
    .clk   (clk),
    .rst   (rst),
    .inc   (bus.credit_signal_i),
    .dec   (send),
    .count (credits)
  );

  assign bus.g_msg_to_pkt_o = grant;
  assign bus.is_valid_o     = send;
  assign bus.out_link_o     = send ? cur_flit : '0;

endmodule

// File: tb/tb_flits_sender.sv
// Table-driven directed bench for flits_sender: one row per clock cycle with hand-computed outputs.
module tb_flits_sender;
  import flits_sender_pkg::*;

  logic clk = 1'b0;
  logic rst;

  flits_sender_if bus ();

  flits_sender #(
    .N_BITS_POINTER (3),
    .N_CREDITS      (4),
    .N_BITS_CREDIT  (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              rst;
    logic              req;
    logic              credit;
    logic              free;
    logic [LINK_W-1:0] link;
    logic              exp_g;
    logic              exp_v;
    flit_t             exp_out;
    int                exp_cred;
    state_t            exp_st;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic flit_t fl(input logic [TYPE_W-1:0] ty, input logic [7:0] payload);
    flit_t f;
    f = '0;
    f[`FLIT_TYPE_BITS] = ty;
    f[7:0] = payload;
    return f;
  endfunction

  // Packet whose flit i has type tys[i] and payload base+i.
  function automatic logic [LINK_W-1:0] pk(input logic [TYPE_W*MAX_FLITS-1:0] tys,
                                           input logic [7:0] base);
    logic [LINK_W-1:0] l;
    for (int i = 0; i < MAX_FLITS; i++) begin
      l[i*FLIT_W +: FLIT_W] = fl(tys[i*TYPE_W +: TYPE_W], base + 8'(i));
    end
    return l;
  endfunction

  task automatic add(input logic r, input logic q, input logic c, input logic f,
                     input logic [LINK_W-1:0] l, input logic g, input logic v,
                     input flit_t o, input int cr, input state_t st);
    vec_t e;
    e.rst = r; e.req = q; e.credit = c; e.free = f; e.link = l;
    e.exp_g = g; e.exp_v = v; e.exp_out = o; e.exp_cred = cr; e.exp_st = st;
    vecs.push_back(e);
  endtask

  logic [LINK_W-1:0] p1, p2, p3, p4;

  initial begin
    p1 = pk({{(MAX_FLITS-1){`BODY_FLIT}}, `HEAD_TAIL_FLIT}, 8'h10);
    p2 = pk({{(MAX_FLITS-4){`BODY_FLIT}}, `TAIL_FLIT, `BODY_FLIT, `BODY_FLIT, `HEAD_FLIT}, 8'h20);
    p3 = pk({{(MAX_FLITS-1){`BODY_FLIT}}, `HEAD_FLIT}, 8'h30);
    p4 = pk({{(MAX_FLITS-4){`BODY_FLIT}}, `TAIL_FLIT, `BODY_FLIT, `BODY_FLIT, `HEAD_FLIT}, 8'h40);

`ifdef NIC_TX_ATOMIC_ALLOC_EN
    // Back-to-back head_tail packets: the second waits for the free pulse.
    add(0, 1, 0, 0, p1, 1, 0, '0, 4, IDLE);
    add(0, 1, 0, 0, p1, 0, 1, fl(`HEAD_TAIL_FLIT, 8'h10), 4, SENDING);
    add(0, 1, 0, 0, p1, 0, 0, '0, 3, WAIT_FREE);
    add(0, 1, 0, 1, p1, 0, 0, '0, 3, WAIT_FREE);
    add(0, 1, 0, 0, p1, 1, 0, '0, 3, IDLE);
    add(0, 0, 0, 0, p1, 0, 1, fl(`HEAD_TAIL_FLIT, 8'h10), 3, SENDING);
    add(0, 0, 0, 0, p1, 0, 0, '0, 2, WAIT_FREE);
`else
    // Single head_tail packet, then credit return and saturation at 4.
    add(0, 1, 0, 0, p1, 1, 0, '0, 4, IDLE);
    add(0, 0, 0, 0, p1, 0, 1, fl(`HEAD_TAIL_FLIT, 8'h10), 4, SENDING);
    add(0, 0, 0, 0, p1, 0, 0, '0, 3, IDLE);
    add(0, 0, 1, 0, p1, 0, 0, '0, 3, IDLE);
    add(0, 0, 1, 0, p1, 0, 0, '0, 4, IDLE);
    // Two more head_tail packets with request held: burn two credits.
    add(0, 1, 0, 0, p1, 1, 0, '0, 4, IDLE);
    add(0, 1, 0, 0, p1, 0, 1, fl(`HEAD_TAIL_FLIT, 8'h10), 4, SENDING);
    add(0, 1, 0, 0, p1, 1, 0, '0, 3, IDLE);
    add(0, 0, 0, 0, p1, 0, 1, fl(`HEAD_TAIL_FLIT, 8'h10), 3, SENDING);
    // Four-flit packet with two credits: stall, then one flit per returned credit.
    add(0, 1, 0, 0, p2, 1, 0, '0, 2, IDLE);
    add(0, 0, 0, 0, p2, 0, 1, fl(`HEAD_FLIT, 8'h20), 2, SENDING);
    add(0, 0, 0, 0, p2, 0, 1, fl(`BODY_FLIT, 8'h21), 1, SENDING);
    add(0, 0, 0, 0, p2, 0, 0, '0, 0, SENDING);
    add(0, 0, 1, 0, p2, 0, 0, '0, 0, SENDING);
    add(0, 0, 1, 0, p2, 0, 1, fl(`BODY_FLIT, 8'h22), 1, SENDING);
    add(0, 0, 0, 0, p2, 0, 1, fl(`TAIL_FLIT, 8'h23), 1, SENDING);
    add(0, 0, 1, 0, p2, 0, 0, '0, 0, IDLE);
    add(0, 0, 1, 0, p2, 0, 0, '0, 1, IDLE);
    add(0, 0, 1, 0, p2, 0, 0, '0, 2, IDLE);
    add(0, 0, 1, 0, p2, 0, 0, '0, 3, IDLE);
    add(0, 0, 0, 0, p2, 0, 0, '0, 4, IDLE);
    // No tail type: packet ends after exactly MAX_FLITS flits; credits returned each send.
    add(0, 1, 1, 0, p3, 1, 0, '0, 4, IDLE);
    for (int i = 0; i < MAX_FLITS; i++) begin
      add(0, 0, 1, 0, p3, 0, 1, fl((i == 0) ? `HEAD_FLIT : `BODY_FLIT, 8'h30 + 8'(i)), 4, SENDING);
    end
    add(0, 0, 0, 0, p3, 0, 0, '0, 4, IDLE);
    add(0, 0, 0, 0, p3, 0, 0, '0, 4, IDLE);
    // Reset after two of four flits drops the rest; a new request is granted at once.
    add(0, 1, 0, 0, p4, 1, 0, '0, 4, IDLE);
    add(0, 0, 0, 0, p4, 0, 1, fl(`HEAD_FLIT, 8'h40), 4, SENDING);
    add(0, 0, 0, 0, p4, 0, 1, fl(`BODY_FLIT, 8'h41), 3, SENDING);
    add(1, 0, 0, 0, p4, 0, 0, '0, 2, SENDING);
    add(0, 1, 0, 0, p1, 1, 0, '0, 4, IDLE);
    add(0, 0, 0, 0, p1, 0, 1, fl(`HEAD_TAIL_FLIT, 8'h10), 4, SENDING);
    add(0, 0, 0, 0, p1, 0, 0, '0, 3, IDLE);
`endif

    // Reset state, with a request pending that must not be granted.
    rst = 1'b1;
    bus.r_msg_to_pkt_i  = 1'b1;
    bus.in_link_i       = p1;
    bus.credit_signal_i = 1'b0;
    bus.free_signal_i   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_grant", 64'(bus.g_msg_to_pkt_o), 64'(0));
    check("rst_valid", 64'(bus.is_valid_o), 64'(0));
    check("rst_out", 64'(bus.out_link_o), 64'(0));
    check("rst_credits", 64'(dut.credits), 64'(4));
    check("rst_state", 64'(dut.state_q), 64'(IDLE));

    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      rst                 = vecs[i].rst;
      bus.r_msg_to_pkt_i  = vecs[i].req;
      bus.in_link_i       = vecs[i].link;
      bus.credit_signal_i = vecs[i].credit;
      bus.free_signal_i   = vecs[i].free;
      @(negedge clk);
      check($sformatf("v%0d_grant", i), 64'(bus.g_msg_to_pkt_o), 64'(vecs[i].exp_g));
      check($sformatf("v%0d_valid", i), 64'(bus.is_valid_o), 64'(vecs[i].exp_v));
      check($sformatf("v%0d_out", i), 64'(bus.out_link_o), 64'(vecs[i].exp_out));
      check($sformatf("v%0d_credits", i), 64'(dut.credits), 64'(vecs[i].exp_cred));
      check($sformatf("v%0d_state", i), 64'(dut.state_q), 64'(vecs[i].exp_st));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/flits_sender.md
FLITS_SENDER -- requirements
Module: flits_sender

Interface
REQ-001 SHALL have parameter N_BITS_POINTER, default 3, the flit index width (clog2 of `MAX_PACKET_LENGHT).
REQ-002 SHALL have parameter N_CREDITS, default 4, the downstream router input-buffer depth in flits.
REQ-003 SHALL have parameter N_BITS_CREDIT, default 3, the credit counter width; it must hold N_CREDITS.
REQ-004 SHALL have port clk, input, 1, the only clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port r_msg_to_pkt_i, input, 1, previous pipeline stage requests transfer of one packet.
REQ-007 SHALL have port in_link_i, input, `MAX_PACKET_LENGHT*`FLIT_WIDTH, packet; flit 0 (bits FLIT_WIDTH-1:0) is head/head_tail, then bodies in order.
REQ-008 SHALL have port g_msg_to_pkt_o, output, 1, grant; packet is captured in the same cycle.
REQ-009 SHALL have port out_link_o, output, `FLIT_WIDTH, flit to the NoC router.
REQ-010 SHALL have port is_valid_o, output, 1, out_link_o carries a valid flit this cycle.
REQ-011 SHALL have port credit_signal_i, input, 1, router freed one flit slot.
REQ-012 SHALL have port free_signal_i, input, 1, router input buffer went busy->idle.

Function
REQ-013 FSM states SHALL be IDLE (3'b001), SENDING (3'b010), WAIT_FREE (3'b100); any other encoding SHALL return to IDLE next cycle.
REQ-014 In IDLE, g_msg_to_pkt_o SHALL equal r_msg_to_pkt_i; on grant all flits are latched, flit pointer cleared to 0, next state SENDING.
REQ-015 g_msg_to_pkt_o SHALL be 0 in SENDING and WAIT_FREE.
REQ-016 In SENDING, is_valid_o SHALL be 1 iff credit counter > 0 (and the downstream-idle flag is set when the pointer is 0 and ATOMIC_ALLOC is compiled in); out_link_o = stored flit[pointer].
REQ-017 Each cycle is_valid_o=1, the pointer SHALL increment by 1 and the credit counter decrement by 1.
REQ-018 A sent flit whose `FLIT_TYPE_BITS field is `TAIL_FLIT or `HEAD_TAIL_FLIT, or a flit sent at pointer `MAX_PACKET_LENGHT-1, SHALL end the packet: next state WAIT_FREE if ATOMIC_ALLOC is compiled in, else IDLE.
REQ-019 First flit SHALL appear no earlier than the cycle after the grant; back-to-back flits every cycle while credits remain.
REQ-020 Credit counter: credit_signal_i alone +1; send alone -1; both in one cycle: unchanged; it SHALL saturate at N_CREDITS and never underflow.
REQ-021 out_link_o SHALL be 0 whenever is_valid_o is 0.
REQ-022 WAIT_FREE SHALL go to IDLE when the downstream-idle flag is set (including free_signal_i in the same cycle); a new grant is not given in WAIT_FREE.

Reset
REQ-023 On rst: state IDLE, pointer 0, credit counter N_CREDITS, downstream-idle flag 1, g_msg_to_pkt_o 0, is_valid_o 0, out_link_o 0.
REQ-024 Reset mid-packet SHALL drop the remaining flits without further is_valid_o; packet storage contents need not be cleared.

Configuration
REQ-025 Macro NIC_TX_ATOMIC_ALLOC_EN SHALL select atomic allocation: when defined, a downstream-idle flag is set by free_signal_i, cleared when a head/head_tail flit is sent, gates head send, and WAIT_FREE is used; when undefined, the flag and WAIT_FREE are absent, free_signal_i is ignored, and only credits gate sending.

Structure
REQ-026 `FLIT_WIDTH, `MAX_PACKET_LENGHT, `N_BITS_FLIT_TYPE, `FLIT_TYPE_BITS and flit-type codes SHALL come from the shared NIC-defines.v; no local redefinition.
REQ-027 The credit counter SHALL be a sub-module credit_counter (parameters N_CREDITS, N_BITS_CREDIT; inputs inc, dec; output count).

Verification
REQ-028 HEAD_TAIL packet, 4 credits: request at cycle 0 -> grant cycle 0, is_valid_o cycle 1 with flit 0, credits 3, then is_valid_o 0.
REQ-029 HEAD+2 BODY+TAIL, 2 credits, no returns: 2 flits on cycles 1-2, stall; one credit_signal_i pulse -> exactly one more flit the next cycle.
REQ-030 Simultaneous credit_signal_i and send with counter 1 -> counter stays 1; credit pulse at counter 4 -> stays 4.
REQ-031 ATOMIC_ALLOC on: two back-to-back HEAD_TAIL packets -> second not granted until free_signal_i pulse; head sent only after flag set.
REQ-032 rst asserted after 2 of 4 flits -> next cycle is_valid_o 0, credits 4, state IDLE, new request granted.
REQ-033 Packet with no tail type in `MAX_PACKET_LENGHT flits -> exactly `MAX_PACKET_LENGHT flits sent, then IDLE/WAIT_FREE.
